// File: rtl/idma_obi_rw_arbiter.sv
// Shares one OBI manager port between the iDMA read and write channels.
// Round-robin A-channel arbitration with grant lock; in-order tracker routes R responses.
module idma_obi_rw_arbiter #(
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned MaxOutstanding = 4,
    parameter type         obi_a_chan_t   = logic [32+1+DataWidth/8+DataWidth-1:0],
    localparam int unsigned CntW          = $clog2(MaxOutstanding + 1),
    localparam int unsigned PtrW          = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  obi_a_chan_t          rd_a_i,
    input  logic                 rd_a_req_i,
    output logic                 rd_a_gnt_o,
    output logic [DataWidth-1:0] rd_r_rdata_o,
    output logic                 rd_r_valid_o,
    input  logic                 rd_r_ready_i,
    input  obi_a_chan_t          wr_a_i,
    input  logic                 wr_a_req_i,
    output logic                 wr_a_gnt_o,
    output logic                 wr_r_valid_o,
    input  logic                 wr_r_ready_i,
    output obi_a_chan_t          obi_a_o,
    output logic                 obi_a_req_o,
    input  logic                 obi_a_gnt_i,
    input  logic [DataWidth-1:0] obi_r_rdata_i,
    input  logic                 obi_r_valid_i,
    output logic                 obi_r_ready_o,
    output logic [CntW-1:0]      outstanding_o,
    output logic                 busy_o,
    output logic                 err_o
);

    logic                      r_lock;
    logic                      r_lock_wr;
    logic                      r_prio_wr;
    logic                      r_err;
    logic [CntW-1:0]           r_count;
    logic [PtrW-1:0]           r_wptr;
    logic [PtrW-1:0]           r_rptr;
    logic [MaxOutstanding-1:0] r_src;

    logic w_full;
    logic w_empty;
    logic w_sel_wr;
    logic w_sel_req;
    logic w_push;
    logic w_pop;
    logic w_head_wr;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + PtrW'(1);
    endfunction

    always_comb begin
        w_full  = (r_count == CntW'(MaxOutstanding));
        w_empty = (r_count == '0);

        // A stalled request keeps its channel until granted, regardless of priority.
        if (r_lock)                      w_sel_wr = r_lock_wr;
        else if (rd_a_req_i && wr_a_req_i) w_sel_wr = r_prio_wr;
        else                             w_sel_wr = wr_a_req_i;

        w_sel_req   = w_sel_wr ? wr_a_req_i : rd_a_req_i;
        obi_a_req_o = w_sel_req & ~w_full;
        obi_a_o     = w_sel_wr ? wr_a_i : rd_a_i;
        rd_a_gnt_o  = obi_a_req_o & ~w_sel_wr & obi_a_gnt_i;
        wr_a_gnt_o  = obi_a_req_o &  w_sel_wr & obi_a_gnt_i;
        w_push      = obi_a_req_o & obi_a_gnt_i;

        w_head_wr     = r_src[r_rptr];
        obi_r_ready_o = ~w_empty & (w_head_wr ? wr_r_ready_i : rd_r_ready_i);
        rd_r_valid_o  = obi_r_valid_i & ~w_empty & ~w_head_wr;
        wr_r_valid_o  = obi_r_valid_i & ~w_empty &  w_head_wr;
        rd_r_rdata_o  = obi_r_rdata_i;
        w_pop         = obi_r_valid_i & obi_r_ready_o;

        outstanding_o = r_count;
        busy_o        = ~w_empty | rd_a_req_i | wr_a_req_i;
        err_o         = r_err;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_lock    <= 1'b0;
            r_lock_wr <= 1'b0;
            r_prio_wr <= 1'b0;
            r_err     <= 1'b0;
            r_count   <= '0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_src     <= '0;
        end else begin
            r_lock <= obi_a_req_o & ~obi_a_gnt_i;
            if (obi_a_req_o && !obi_a_gnt_i) r_lock_wr <= w_sel_wr;

            if (w_push) begin
                r_src[r_wptr] <= w_sel_wr;
                r_wptr        <= ptr_inc(r_wptr);
                r_prio_wr     <= ~w_sel_wr;
            end
            if (w_pop) r_rptr <= ptr_inc(r_rptr);

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CntW'(1);
                2'b01:   r_count <= r_count - CntW'(1);
                default: r_count <= r_count;
            endcase

            // A response with nothing outstanding is a protocol error; sticky until reset.
            if (obi_r_valid_i && w_empty) r_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_idma_obi_rw_arbiter.sv
// Scoreboard bench for idma_obi_rw_arbiter: stimulus queues expected grants and
// responses, a negedge monitor pops and compares them.
module tb_idma_obi_rw_arbiter;

    localparam int PW = 69;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [PW-1:0] rd_a, wr_a, obi_a;
    logic          rd_req, wr_req, rd_gnt, wr_gnt;
    logic [31:0]   rd_rdata, obi_rdata;
    logic          rd_rv, wr_rv, rd_rdy, wr_rdy;
    logic          a_req, a_gnt, r_valid, r_ready;
    logic [2:0]    outstanding;
    logic          busy, err;

    always #5 clk = ~clk;

    idma_obi_rw_arbiter dut (
        .clk_i(clk), .rst_ni(rst_n),
        .rd_a_i(rd_a), .rd_a_req_i(rd_req), .rd_a_gnt_o(rd_gnt),
        .rd_r_rdata_o(rd_rdata), .rd_r_valid_o(rd_rv), .rd_r_ready_i(rd_rdy),
        .wr_a_i(wr_a), .wr_a_req_i(wr_req), .wr_a_gnt_o(wr_gnt),
        .wr_r_valid_o(wr_rv), .wr_r_ready_i(wr_rdy),
        .obi_a_o(obi_a), .obi_a_req_o(a_req), .obi_a_gnt_i(a_gnt),
        .obi_r_rdata_i(obi_rdata), .obi_r_valid_i(r_valid), .obi_r_ready_o(r_ready),
        .outstanding_o(outstanding), .busy_o(busy), .err_o(err)
    );

    typedef struct packed { logic wr; logic [PW-1:0] pl; } gexp_t;
    typedef struct packed { logic rv; logic wv; logic rdy; logic [31:0] d; } rexp_t;
    gexp_t gq[$];
    rexp_t rq[$];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic resp(input logic [31:0] d, input logic rr, input logic wrr,
                        input logic erv, input logic ewv, input logic erdy);
        obi_rdata = d; r_valid = 1'b1; rd_rdy = rr; wr_rdy = wrr;
        rq.push_back('{erv, ewv, erdy, d});
        tick();
        r_valid = 1'b0; rd_rdy = 1'b0; wr_rdy = 1'b0;
    endtask

    // Monitor: one grant expectation per accepted A request, one response
    // expectation per cycle with shared-port R valid.
    always @(negedge clk) begin
        if (rst_n) begin
            if (a_req && a_gnt) begin
                if (gq.size() == 0) chk("unexpected_grant", 1, 0);
                else begin
                    gexp_t e;
                    e = gq.pop_front();
                    chk("grant_rd", PW'(rd_gnt), PW'(!e.wr));
                    chk("grant_wr", PW'(wr_gnt), PW'(e.wr));
                    chk("grant_payload", obi_a, e.pl);
                end
            end
            if (r_valid) begin
                if (rq.size() == 0) chk("unexpected_resp", 1, 0);
                else begin
                    rexp_t r;
                    r = rq.pop_front();
                    chk("resp_rd_valid", PW'(rd_rv), PW'(r.rv));
                    chk("resp_wr_valid", PW'(wr_rv), PW'(r.wv));
                    chk("resp_ready", PW'(r_ready), PW'(r.rdy));
                    if (r.rv) chk("resp_rdata", PW'(rd_rdata), PW'(r.d));
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; rd_req = 0; wr_req = 0; rd_a = '0; wr_a = '0; a_gnt = 0;
        r_valid = 0; obi_rdata = '0; rd_rdy = 0; wr_rdy = 0;
        #1;
        chk("rst_outstanding", PW'(outstanding), 0);
        chk("rst_err", PW'(err), 0);
        chk("rst_a_req", PW'(a_req), 0);
        chk("rst_gnts", PW'({rd_gnt, wr_gnt}), 0);
        chk("rst_rvalids", PW'({rd_rv, wr_rv, r_ready}), 0);
        chk("rst_busy", PW'(busy), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single read grant
        rd_a = PW'(69'h0_1000_0000_AAAA_0001); rd_req = 1; a_gnt = 1;
        gq.push_back('{1'b0, rd_a});
        #1;
        chk("t1_obi_a", obi_a, rd_a);
        chk("t1_out_before", PW'(outstanding), 0);
        tick();
        chk("t1_out_after", PW'(outstanding), 1);
        rd_req = 0; a_gnt = 0;
        resp(32'hD000_0001, 1, 0, 1, 0, 1);
        chk("t1_out_drained", PW'(outstanding), 0);

        // Single write grant (priority returns to read)
        wr_a = PW'(69'h1_2000_0000_BBBB_0000); wr_req = 1; a_gnt = 1;
        gq.push_back('{1'b1, wr_a});
        tick();
        wr_req = 0; a_gnt = 0;
        resp(32'hD000_0002, 0, 1, 0, 1, 1);
        chk("wr_out_drained", PW'(outstanding), 0);

        // Both requesting: rd, wr, rd, wr until full
        for (int i = 0; i < 4; i++) begin
            rd_a = PW'(69'h0_3000_0000_0000_0000) + PW'(i);
            wr_a = PW'(69'h1_4000_0000_0000_0000) + PW'(i);
            rd_req = 1; wr_req = 1; a_gnt = 1;
            gq.push_back((i % 2 == 0) ? '{1'b0, rd_a} : '{1'b1, wr_a});
            tick();
        end
        chk("full_outstanding", PW'(outstanding), 4);
        #1;
        chk("full_a_req", PW'(a_req), 0);
        chk("full_gnts", PW'({rd_gnt, wr_gnt}), 0);
        chk("full_busy", PW'(busy), 1);

        // Pop while full: no same-cycle bypass
        obi_rdata = 32'hD000_0003; r_valid = 1; rd_rdy = 1;
        rq.push_back('{1'b1, 1'b0, 1'b1, 32'hD000_0003});
        #1;
        chk("pop_full_no_bypass", PW'(a_req), 0);
        tick();
        r_valid = 0; rd_rdy = 0;
        chk("pop_full_out", PW'(outstanding), 3);
        rd_a = PW'(69'h0_5000_0000_0000_0005);
        gq.push_back('{1'b0, rd_a});
        tick();
        chk("refill_out", PW'(outstanding), 4);
        rd_req = 0; wr_req = 0; a_gnt = 0;

        // Tracker now wr, rd, wr, rd. Head wr not ready: stall, no pop
        obi_rdata = 32'hD000_0004; r_valid = 1; rd_rdy = 1; wr_rdy = 0;
        rq.push_back('{1'b0, 1'b1, 1'b0, 32'hD000_0004});
        tick();
        r_valid = 0; rd_rdy = 0;
        chk("stall_no_pop", PW'(outstanding), 4);
        resp(32'hD000_0004, 0, 1, 0, 1, 1);
        resp(32'hD000_0005, 1, 0, 1, 0, 1);
        resp(32'hD000_0006, 0, 1, 0, 1, 1);
        resp(32'hD000_0007, 1, 0, 1, 0, 1);
        chk("drain_out", PW'(outstanding), 0);

        // Lock: rd stalls, wr has priority but must wait for rd's grant
        rd_a = PW'(69'h0_6000_0000_CCCC_0006); rd_req = 1; a_gnt = 0;
        #1;
        chk("lock_c0_payload", obi_a, rd_a);
        chk("lock_c0_req", PW'(a_req), 1);
        tick();
        wr_a = PW'(69'h1_7000_0000_DDDD_0007); wr_req = 1;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("lock_hold_payload", obi_a, rd_a);
            chk("lock_hold_gnts", PW'({rd_gnt, wr_gnt}), 0);
            tick();
        end
        a_gnt = 1;
        gq.push_back('{1'b0, rd_a});
        tick();
        rd_req = 0;
        gq.push_back('{1'b1, wr_a});
        // Same-cycle grant and pop
        obi_rdata = 32'hD000_0008; r_valid = 1; rd_rdy = 1;
        rq.push_back('{1'b1, 1'b0, 1'b1, 32'hD000_0008});
        tick();
        chk("push_pop_out", PW'(outstanding), 1);
        wr_req = 0; a_gnt = 0; r_valid = 0; rd_rdy = 0;
        resp(32'hD000_0009, 0, 1, 0, 1, 1);
        chk("lock_drain_out", PW'(outstanding), 0);

        // Response with empty tracker
        obi_rdata = 32'hD000_000A; r_valid = 1; rd_rdy = 1; wr_rdy = 1;
        rq.push_back('{1'b0, 1'b0, 1'b0, 32'hD000_000A});
        #1;
        chk("err_before", PW'(err), 0);
        tick();
        r_valid = 0; rd_rdy = 0; wr_rdy = 0;
        chk("err_set", PW'(err), 1);
        tick();
        chk("err_sticky", PW'(err), 1);
        rst_n = 0;
        #1;
        chk("err_cleared_by_reset", PW'(err), 0);
        tick();
        rst_n = 1;

        // Async reset with a request outstanding
        rd_a = PW'(69'h0_8000_0000_0000_0008); rd_req = 1; a_gnt = 1;
        gq.push_back('{1'b0, rd_a});
        tick();
        rd_req = 0; a_gnt = 0;
        chk("pre_reset_out", PW'(outstanding), 1);
        #2 rst_n = 0;
        #1;
        chk("async_reset_out", PW'(outstanding), 0);
        tick();
        rst_n = 1;
        tick();

        chk("grant_queue_empty", PW'(gq.size()), 0);
        chk("resp_queue_empty", PW'(rq.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
